victim_cache_ctrl: RTL and testbench

Parametrised controller for the L2 victim cache (VC), between the L2 eviction path and physical memory. It tracks per-way valid/dirty state internally and owns a true-LRU replacement unit. It selects victims (invalid way first, then LRU), writes dirty victims back to memory, and cleans dirty ways in the background when L2 is idle. It also supports an exclusive (swap-on-read-hit) mode and a software-visible flush.

---
 rtl/vc_pkg.sv | 21 ++
 rtl/victim_cache_ctrl_if.sv | 41 ++++
 rtl/vc_lru.sv | 39 +++
 rtl/victim_cache_ctrl.sv | 154 +++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/vc_pkg.sv
// vc_pkg: shared types and helpers for the victim cache controller.
//   vc_state_e  - controller FSM states (IDLE / WB / GAP)
//   lowest_set  - index of the lowest set bit of a vector of up to 32 bits
package vc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        GAP  = 2'd2
    } vc_state_e;

    // Returns 0 for an all-zero vector; callers only use the result when a
    // bit is known to be set.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// victim_cache_ctrl_if: request/response bundle between L2, pmem and the
// victim cache controller.
//   master - L2 / pmem side: drives requests, hit info, mem_ack, flush_req
//   slave  - controller side: drives valid vector, array strobes, acks
interface victim_cache_ctrl_if #(
    parameter int NUM_WAYS = 8,
    parameter int WAY_W    = $clog2(NUM_WAYS)
);
    logic                l2_read;
    logic                l2_write;
    logic                l2_dirty;
    logic                l2_to_pmem_busy;
    logic                vc_hit;
    logic [WAY_W-1:0]    hit_way;
    logic                mem_ack;
    logic                flush_req;

    logic [NUM_WAYS-1:0] vc_valid;
    logic [WAY_W-1:0]    data_way;
    logic                load_vc;
    logic                vc_ack;
    logic                vc_rd_dirty;
    logic                vc_write;
    logic                foh;
    logic [WAY_W:0]      dirty_count;
    logic                flush_done;

    modport master (
        output l2_read, l2_write, l2_dirty, l2_to_pmem_busy, vc_hit, hit_way,
               mem_ack, flush_req,
        input  vc_valid, data_way, load_vc, vc_ack, vc_rd_dirty, vc_write,
               foh, dirty_count, flush_done
    );

    modport slave (
        input  l2_read, l2_write, l2_dirty, l2_to_pmem_busy, vc_hit, hit_way,
               mem_ack, flush_req,
        output vc_valid, data_way, load_vc, vc_ack, vc_rd_dirty, vc_write,
               foh, dirty_count, flush_done
    );
endinterface

// File: rtl/vc_lru.sv
// vc_lru: true-LRU replacement using per-way age counters.
//   clk, rst_n  - clock, async active-low reset (age[i] = i)
//   touch       - mark touch_way most recently used this cycle
//   touch_way   - way being touched
//   lru_way     - way whose age is NUM_WAYS-1
module vc_lru #(
    parameter int NUM_WAYS = 8,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] lru_way
);
    logic [NUM_WAYS-1:0][WAY_W-1:0] age_q;

    // Ages always form a permutation of 0..NUM_WAYS-1: the touched way goes
    // to 0 and everything younger than it shifts up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= WAY_W'(i);
        end else if (touch) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (WAY_W'(i) == touch_way)
                    age_q[i] <= '0;
                else if (age_q[i] < age_q[touch_way])
                    age_q[i] <= age_q[i] + WAY_W'(1);
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (age_q[i] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(i);
        end
    end
endmodule

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: L2 victim cache controller.
//   clk, rst_n - clock, async active-low reset
//   bus        - slave side of victim_cache_ctrl_if (L2 requests, pmem
//                handshake, array strobes, valid vector, dirty count, flush)
// Tracks per-way valid/dirty, picks victims (invalid first, then LRU),
// writes dirty victims back, cleans in the background and on flush.
module victim_cache_ctrl
    import vc_pkg::*;
#(
    parameter int NUM_WAYS     = 8,
    parameter int WAY_W        = $clog2(NUM_WAYS),
    parameter int CLEAN_THRESH = 2,
    parameter int EXCLUSIVE    = 0
) (
    input logic               clk,
    input logic               rst_n,
    victim_cache_ctrl_if.slave bus
);
    localparam int CW = WAY_W + 1;
    localparam logic [CW-1:0] THRESH = CW'(CLEAN_THRESH);

    vc_state_e           state_q, state_d;
    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_WAYS-1:0] dirty_q, dirty_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                pend_q, pend_d;
    logic [WAY_W-1:0]    wb_way_q, wb_way_d;

    logic [WAY_W-1:0]    lru_way, victim, clean_way, way_c, touch_way;
    logic                touch, load_c, ack_c, rdd_c, foh_c, done_c;
    logic                can_clean, flush_go, bg_go;

    vc_lru #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .touch     (touch),
        .touch_way (touch_way),
        .lru_way   (lru_way)
    );

    assign victim    = (&valid_q) ? lru_way : WAY_W'(lowest_set(32'(~valid_q)));
    assign clean_way = WAY_W'(lowest_set(32'(dirty_q)));
    assign can_clean = !bus.l2_read && !bus.l2_write && !bus.l2_to_pmem_busy;
    assign flush_go  = can_clean && pend_q && (dcnt_q != '0);
    assign bg_go     = can_clean && (CLEAN_THRESH != 0) && (dcnt_q >= THRESH);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        pend_d    = pend_q | bus.flush_req;
        wb_way_d  = wb_way_q;
        touch     = 1'b0;
        touch_way = bus.hit_way;
        way_c     = '0;
        load_c    = 1'b0;
        ack_c     = 1'b0;
        rdd_c     = 1'b0;
        foh_c     = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.l2_write) begin
                    if (bus.vc_hit) begin
                        load_c = 1'b1;
                        ack_c  = 1'b1;
                        way_c  = bus.hit_way;
                        touch  = 1'b1;
                        dirty_d[bus.hit_way] = dirty_q[bus.hit_way] | bus.l2_dirty;
                        state_d = GAP;
                    end else if (dirty_q[victim]) begin
                        // Write back first; the request is re-evaluated in
                        // IDLE afterwards and finds the same, now clean, victim.
                        way_c    = victim;
                        wb_way_d = victim;
                        state_d  = WB;
                    end else begin
                        load_c    = 1'b1;
                        ack_c     = 1'b1;
                        way_c     = victim;
                        touch     = 1'b1;
                        touch_way = victim;
                        valid_d[victim] = 1'b1;
                        dirty_d[victim] = bus.l2_dirty;
                        state_d = GAP;
                    end
                end else if (bus.l2_read) begin
                    if (bus.vc_hit) begin
                        ack_c = 1'b1;
                        way_c = bus.hit_way;
                        rdd_c = dirty_q[bus.hit_way];
                        touch = 1'b1;
                        if (EXCLUSIVE != 0) begin
                            valid_d[bus.hit_way] = 1'b0;
                            dirty_d[bus.hit_way] = 1'b0;
                        end
                        state_d = GAP;
                    end else begin
                        foh_c = 1'b1;
                    end
                end else if (pend_q && dcnt_q == '0) begin
                    done_c = 1'b1;
                    pend_d = 1'b0;
                end else if (flush_go || bg_go) begin
                    way_c    = clean_way;
                    wb_way_d = clean_way;
                    state_d  = WB;
                end
            end
            WB: begin
                way_c = wb_way_q;
                if (bus.mem_ack) begin
                    dirty_d[wb_way_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dcnt_d = '0;
        for (int i = 0; i < NUM_WAYS; i++) dcnt_d = dcnt_d + CW'(dirty_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            dcnt_q   <= '0;
            pend_q   <= 1'b0;
            wb_way_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            dcnt_q   <= dcnt_d;
            pend_q   <= pend_d;
            wb_way_q <= wb_way_d;
        end
    end

    assign bus.vc_valid    = valid_q;
    assign bus.data_way    = way_c;
    assign bus.load_vc     = load_c;
    assign bus.vc_ack      = ack_c;
    assign bus.vc_rd_dirty = rdd_c;
    assign bus.vc_write    = (state_q == WB);
    assign bus.foh         = foh_c;
    assign bus.dirty_count = dcnt_q;
    assign bus.flush_done  = done_c;
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb_victim_cache_ctrl: directed self-checking bench for victim_cache_ctrl
// (NUM_WAYS=8, CLEAN_THRESH=2, EXCLUSIVE=1) with a fixed-latency pmem model.
module tb_victim_cache_ctrl;
    localparam int MEM_LAT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    victim_cache_ctrl_if #(.NUM_WAYS(8)) vif ();

    victim_cache_ctrl #(
        .NUM_WAYS(8), .CLEAN_THRESH(2), .EXCLUSIVE(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    int n_tot = 0;
    int n_bad = 0;
    int wcnt = 0;
    int wr_cycles = 0;
    int done_cnt = 0;
    logic [2:0] wb_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pmem model: acks in the MEM_LAT-th cycle of each vc_write burst.
    initial begin
        vif.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            vif.mem_ack = 1'b0;
            if (vif.vc_write) begin
                wr_cycles++;
                wcnt++;
                if (wcnt == MEM_LAT) begin
                    vif.mem_ack = 1'b1;
                    wcnt = 0;
                    wb_log.push_back(vif.data_way);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (vif.flush_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a request until vc_ack (bounded), then checks the GAP bubble.
    task automatic do_req(input logic rd, input logic dty, input logic hit, input logic [2:0] hw,
                          output int cyc, output logic [2:0] way, output logic rdd);
        bit got;
        got = 0;
        cyc = 0; way = '0; rdd = 1'b0;
        vif.l2_read = rd; vif.l2_write = !rd; vif.l2_dirty = dty;
        vif.vc_hit = hit; vif.hit_way = hw;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (vif.vc_ack) begin
                got = 1;
                way = vif.data_way;
                rdd = vif.vc_rd_dirty;
                chk("load_vc", vif.load_vc, !rd);
            end
            @(posedge clk); #1;
        end
        vif.l2_read = 0; vif.l2_write = 0; vif.vc_hit = 0; vif.l2_dirty = 0;
        if (!got) chk("req_timeout", 0, 1);
        @(negedge clk);
        chk("gap_ack", vif.vc_ack, 0);
        @(posedge clk); #1;
    endtask

    task automatic wr_chk(input string tag, input logic hit, input logic [2:0] hw, input logic dty,
                          input logic [2:0] exp_way, input int exp_cyc);
        int c; logic [2:0] w; logic r;
        do_req(1'b0, dty, hit, hw, c, w, r);
        chk({tag, "_way"}, w, exp_way);
        chk({tag, "_lat"}, c, exp_cyc);
    endtask

    int c, d0, n0;
    logic [2:0] w;
    logic r;

    initial begin
        vif.l2_read = 0; vif.l2_write = 0; vif.l2_dirty = 0; vif.l2_to_pmem_busy = 0;
        vif.vc_hit = 0; vif.hit_way = '0; vif.flush_req = 0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", vif.vc_valid, 0);
        chk("rst_dcnt", vif.dirty_count, 0);
        chk("rst_way", vif.data_way, 0);
        chk("rst_ack", vif.vc_ack, 0);
        chk("rst_write", vif.vc_write, 0);
        chk("rst_load", vif.load_vc, 0);
        chk("rst_foh", vif.foh, 0);
        chk("rst_done", vif.flush_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // fill ways 0..7 with clean write misses
        for (int i = 0; i < 8; i++) wr_chk("fill", 1'b0, 3'd0, 1'b0, 3'(i), 1);
        chk("fill_valid", vif.vc_valid, 8'hff);
        chk("fill_dcnt", vif.dirty_count, 0);

        // touch 0..6, then miss must pick LRU way 7
        for (int i = 0; i < 7; i++) wr_chk("touch", 1'b1, 3'(i), 1'b0, 3'(i), 1);
        wr_chk("lru_victim", 1'b0, 3'd0, 1'b0, 3'd7, 1);

        // dirty LRU way 0, then miss: WB (5 cycles) + install = 7 cycles
        wr_chk("mk_dirty", 1'b1, 3'd0, 1'b1, 3'd0, 1);
        chk("mk_dirty_dcnt", vif.dirty_count, 1);
        for (int i = 1; i < 8; i++) wr_chk("touch2", 1'b1, 3'(i), 1'b0, 3'(i), 1);
        wb_log.delete();
        wr_chk("dirty_victim", 1'b0, 3'd0, 1'b0, 3'd0, 7);
        chk("dv_wb_cnt", wb_log.size(), 1);
        chk("dv_wb_way", wb_log[0], 0);
        chk("dv_dcnt", vif.dirty_count, 0);

        // background clean held off by l2_to_pmem_busy
        vif.l2_to_pmem_busy = 1;
        wr_chk("bg_d1", 1'b1, 3'd1, 1'b1, 3'd1, 1);
        wr_chk("bg_d4", 1'b1, 3'd4, 1'b1, 3'd4, 1);
        chk("bg_dcnt2", vif.dirty_count, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bg_hold", vif.vc_write, 0);
            @(posedge clk); #1;
        end
        vif.l2_to_pmem_busy = 0;
        for (int k = 0; k < 30 && vif.dirty_count != 1; k++) tick(1);
        chk("bg_dcnt1", vif.dirty_count, 1);
        chk("bg_wb_cnt", wb_log.size(), 2);
        chk("bg_wb_way", wb_log[$], 1);
        d0 = wr_cycles;
        tick(10);
        chk("bg_stop", wr_cycles - d0, 0);
        chk("bg_dcnt_hold", vif.dirty_count, 1);

        // exclusive read hit on dirty way 3, then a read miss
        vif.l2_to_pmem_busy = 1;
        wr_chk("ex_d3", 1'b1, 3'd3, 1'b1, 3'd3, 1);
        chk("ex_dcnt2", vif.dirty_count, 2);
        do_req(1'b1, 1'b0, 1'b1, 3'd3, c, w, r);
        chk("ex_lat", c, 1);
        chk("ex_way", w, 3);
        chk("ex_rdd", r, 1);
        chk("ex_valid3", vif.vc_valid[3], 0);
        chk("ex_dcnt1", vif.dirty_count, 1);
        vif.l2_read = 1; vif.vc_hit = 0;
        @(negedge clk);
        chk("miss_foh", vif.foh, 1);
        chk("miss_ack", vif.vc_ack, 0);
        chk("miss_load", vif.load_vc, 0);
        @(posedge clk); #1;
        vif.l2_read = 0;
        @(negedge clk);
        chk("miss_foh_clr", vif.foh, 0);
        @(posedge clk); #1;

        // flush below threshold: way 4 only
        vif.l2_to_pmem_busy = 0;
        d0 = done_cnt;
        vif.flush_req = 1; tick(1); vif.flush_req = 0;
        for (int k = 0; k < 40 && done_cnt == d0; k++) tick(1);
        chk("fl1_done", done_cnt - d0, 1);
        chk("fl1_wb_way", wb_log[$], 4);
        chk("fl1_dcnt", vif.dirty_count, 0);

        // flush ways 2,5 with a write arriving during the first writeback
        vif.l2_to_pmem_busy = 1;
        wr_chk("fl_d2", 1'b1, 3'd2, 1'b1, 3'd2, 1);
        wr_chk("fl_d5", 1'b1, 3'd5, 1'b1, 3'd5, 1);
        chk("fl_dcnt2", vif.dirty_count, 2);
        d0 = done_cnt;
        n0 = wb_log.size();
        vif.flush_req = 1; tick(1); vif.flush_req = 0;
        vif.l2_to_pmem_busy = 0;
        tick(2);
        wr_chk("fl_mid_wr", 1'b1, 3'd6, 1'b0, 3'd6, 5);
        chk("fl_order", wb_log.size() - n0, 1);
        for (int k = 0; k < 40 && done_cnt == d0; k++) tick(1);
        chk("fl2_done", done_cnt - d0, 1);
        chk("fl2_wb_cnt", wb_log.size() - n0, 2);
        chk("fl2_wb_a", wb_log[n0], 2);
        chk("fl2_wb_b", wb_log[n0 + 1], 5);
        chk("fl2_dcnt", vif.dirty_count, 0);
        tick(5);
        chk("fl2_single", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
